mips_multi_ctrl_v2: RTL
=======================

// Module: mips_multi_ctrl_v2
// PURPOSE
// Second-generation multicycle MIPS controller: FSM + ALU decoder driving the shared multicycle datapath.
// Adds bne, andi, ori, slti and jal, plus a mem_ready wait-state handshake with a timeout trap.
// Sits between instruction/memory interface and datapath; one instruction every 3-5+ cycles.
// PARAMETERS
// TIMEOUT   16  max consecutive wait cycles on mem_ready before trap; 0 = no timeout
// CNT_W     5   wait-counter width; must hold TIMEOUT
// PORTS
// clk         in   1  clock
// reset       in   1  async active-high reset
// op          in   6  instr[31:26]
// funct       in   6  instr[5:0]
// zero        in   1  ALU zero flag
// mem_ready   in   1  memory completes current access this cycle
// pcen        out  1  PC register enable
// memwrite    out  1  memory write strobe
// irwrite     out  1  instruction register enable
// regwrite    out  1  register file write enable
// alusrca     out  1  0=PC, 1=A
// iord        out  1  0=PC address, 1=ALUOut address
// memtoreg    out  2  00=ALUOut, 01=data reg, 10=PC (jal link)
// regdst      out  2  00=rt, 01=rd, 10=r31
// alusrcb     out  2  00=B, 01=4, 10=imm, 11=imm<<2
// pcsrc       out  2  00=ALU result, 01=ALUOut, 10=jump target
// zext        out  1  1=zero-extend immediate (andi/ori)
// alucontrol  out  3  010 add,110 sub,000 and,001 or,111 slt
// state       out  4  current FSM state (debug)
// trap        out  1  sticky error flag
// trap_cause  out  2  01 timeout, 10 illegal op/funct
// BEHAVIOUR
// Reset (async, clk for release): state=FETCH, wait counter=0, trap=0, trap_cause=00; outputs = FETCH decode.
// States: 0 FETCH,1 DECODE,2 MEMADR,3 MEMRD,4 MEMWB,5 MEMWR,6 RTYPEEX,7 RTYPEWB,8 BEQEX,9 BNEEX,
//   10 IMMEX,11 IMMWB,12 JEX,13 JALEX,14 ERR. Unlisted outputs are 0 in every state.
// FETCH: iord=0,alusrca=0,alusrcb=01,add,pcsrc=00; irwrite=pcwrite=mem_ready; stay until mem_ready -> DECODE.
// DECODE: alusrcb=11,add (branch target to ALUOut). lw/sw->MEMADR, R->RTYPEEX, beq->BEQEX, bne->BNEEX,
//   addi/andi/ori/slti->IMMEX, j->JEX, jal->JALEX, else illegal (see CONFIGURATION).
// MEMADR: alusrca=1,alusrcb=10,add; lw->MEMRD, sw->MEMWR.
// MEMRD: iord=1; hold until mem_ready -> MEMWB. MEMWB: regwrite=1,regdst=00,memtoreg=01 -> FETCH.
// MEMWR: iord=1,memwrite=1 held every cycle until mem_ready -> FETCH.
// RTYPEEX: alusrca=1,alusrcb=00,funct decode -> RTYPEWB: regwrite,regdst=01,memtoreg=00 -> FETCH.
// BEQEX/BNEEX: alusrca=1,alusrcb=00,sub,pcsrc=01; pcen=zero (beq) / ~zero (bne) -> FETCH.
// IMMEX: alusrca=1,alusrcb=10; alucontrol addi 010, andi 000, ori 001, slti 111; zext=1 for andi/ori -> IMMWB.
// IMMWB: regwrite,regdst=00,memtoreg=00, zext kept -> FETCH.
// JEX: pcsrc=10,pcen=1 -> FETCH. JALEX: regwrite,regdst=10,memtoreg=10 (PC already +4), pcsrc=10,pcen=1 -> FETCH.
// pcen = pcwrite | (beq_state & zero) | (bne_state & ~zero); combinational from state and zero.
// Wait counter: clears on entry to FETCH/MEMRD/MEMWR and on mem_ready; increments each non-ready cycle there.
// TIMEOUT>0 and counter reaches TIMEOUT-1 with mem_ready=0 -> ERR, trap=1, trap_cause=01.
// mem_ready in same cycle as the timeout limit wins: access completes, no trap.
// ERR: all strobes 0, pcen=0; stays until reset. trap/trap_cause sticky until reset.
// mem_ready outside FETCH/MEMRD/MEMWR is ignored. Reset mid-access aborts instantly to FETCH, no write.
// CONFIGURATION
// ILLEGAL_TRAP_EN defined: unsupported op in DECODE, or unsupported funct in RTYPEEX, -> ERR, trap_cause=10.
// ILLEGAL_TRAP_EN undefined: unsupported op -> FETCH (NOP, PC already +4); unsupported funct gives
//   alucontrol=010 and completes normally; trap_cause never 10.
// TESTING
// add $3,$1,$2, mem_ready=1 always -> states 0,1,6,7,0; regdst=01 regwrite=1 in state 7; 4 cycles.
// lw with mem_ready low 3 cycles in MEMRD -> state 3 held 4 cycles, MEMWB once, no trap.
// bne with zero=0 -> pcen=1 in BNEEX; zero=1 -> pcen=0; beq mirror.
// ori -> zext=1, alucontrol=001 in IMMEX/IMMWB; jal -> regdst=10,memtoreg=10,pcsrc=10,pcen=1.
// TIMEOUT=4, mem_ready=0 in FETCH -> ERR after 4 cycles, trap=1,cause=01; ready on 4th cycle -> DECODE.
// op=6'b111111: with ILLEGAL_TRAP_EN -> ERR, cause=10; without -> FETCH, trap=0; reset clears trap.

Source files
------------

// File: rtl/mips_multi_ctrl_v2_if.sv
// Control bundle between the multicycle MIPS controller (master) and the
// datapath/memory side (slave).
interface mips_multi_ctrl_v2_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pcen;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       alusrca;
   logic       iord;
   logic [1:0] memtoreg;
   logic [1:0] regdst;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic       zext;
   logic [2:0] alucontrol;
   logic [3:0] state;
   logic       trap;
   logic [1:0] trap_cause;

   modport master (
      input  op, funct, zero, mem_ready,
      output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
             regdst, alusrcb, pcsrc, zext, alucontrol, state, trap, trap_cause
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
             regdst, alusrcb, pcsrc, zext, alucontrol, state, trap, trap_cause
   );
endinterface

// File: rtl/mips_multi_ctrl_v2.sv
// Multicycle MIPS controller: main FSM, ALU decode, mem_ready wait states with timeout trap.
// Define ILLEGAL_TRAP_EN to trap unsupported opcodes/functs instead of treating them as NOP/add.
module mips_multi_ctrl_v2 #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   mips_multi_ctrl_v2_if.master bus
);
   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB   = 4'd4,  S_MEMWR   = 4'd5,  S_RTYPEEX = 4'd6, S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,  S_BNEEX   = 4'd9,  S_IMMEX  = 4'd10, S_IMMWB = 4'd11,
      S_JEX     = 4'd12, S_JALEX   = 4'd13, S_ERR    = 4'd14
   } state_e;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

   localparam bit               TO_EN   = (TIMEOUT > 0);
   localparam logic [CNT_W-1:0] CNT_LIM = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             trap_q, trap_d;
   logic [1:0]       cause_q, cause_d;

   logic       wait_st, timeout_hit, pcwrite, imm_zext;
   logic [2:0] r_alu, i_alu;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         trap_q  <= 1'b0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trap_q  <= trap_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      r_alu = ALU_ADD;
      case (bus.funct)
         F_ADD:   r_alu = ALU_ADD;
         F_SUB:   r_alu = ALU_SUB;
         F_AND:   r_alu = ALU_AND;
         F_OR:    r_alu = ALU_OR;
         F_SLT:   r_alu = ALU_SLT;
         default: r_alu = ALU_ADD;
      endcase
   end

   always_comb begin
      i_alu = ALU_ADD;
      case (bus.op)
         OP_ANDI: i_alu = ALU_AND;
         OP_ORI:  i_alu = ALU_OR;
         OP_SLTI: i_alu = ALU_SLT;
         default: i_alu = ALU_ADD;
      endcase
   end

   assign imm_zext = (bus.op == OP_ANDI) || (bus.op == OP_ORI);

`ifdef ILLEGAL_TRAP_EN
   logic funct_ok;
   assign funct_ok = bus.funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
`endif

   // Counter only runs while a memory access is stalled; any other cycle clears it.
   assign wait_st     = state_q inside {S_FETCH, S_MEMRD, S_MEMWR};
   assign timeout_hit = TO_EN && wait_st && !bus.mem_ready && (cnt_q == CNT_LIM);
   assign cnt_d       = (wait_st && !bus.mem_ready) ? cnt_q + CNT_W'(1) : '0;

   always_comb begin
      state_d        = state_q;
      trap_d         = trap_q;
      cause_d        = cause_q;
      pcwrite        = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.regwrite   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.iord       = 1'b0;
      bus.memtoreg   = 2'b00;
      bus.regdst     = 2'b00;
      bus.alusrcb    = 2'b00;
      bus.pcsrc      = 2'b00;
      bus.zext       = 1'b0;
      bus.alucontrol = 3'b000;

      case (state_q)
         S_FETCH: begin
            bus.alusrcb    = 2'b01;
            bus.alucontrol = ALU_ADD;
            bus.irwrite    = bus.mem_ready;
            pcwrite        = bus.mem_ready;
            if (bus.mem_ready) state_d = S_DECODE;
            else if (timeout_hit) begin
               state_d = S_ERR; trap_d = 1'b1; cause_d = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            bus.alusrcb    = 2'b11;
            bus.alucontrol = ALU_ADD;
            case (bus.op)
               OP_LW, OP_SW:                     state_d = S_MEMADR;
               OP_R:                             state_d = S_RTYPEEX;
               OP_BEQ:                           state_d = S_BEQEX;
               OP_BNE:                           state_d = S_BNEEX;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEX;
               OP_J:                             state_d = S_JEX;
               OP_JAL:                           state_d = S_JALEX;
`ifdef ILLEGAL_TRAP_EN
               default: begin
                  state_d = S_ERR; trap_d = 1'b1; cause_d = CAUSE_ILLEGAL;
               end
`else
               // PC is already +4, so an unknown opcode retires as a NOP.
               default:                          state_d = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: begin
            bus.alusrca    = 1'b1;
            bus.alusrcb    = 2'b10;
            bus.alucontrol = ALU_ADD;
            state_d        = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            bus.iord = 1'b1;
            if (bus.mem_ready) state_d = S_MEMWB;
            else if (timeout_hit) begin
               state_d = S_ERR; trap_d = 1'b1; cause_d = CAUSE_TIMEOUT;
            end
         end
         S_MEMWB: begin
            bus.regwrite = 1'b1;
            bus.memtoreg = 2'b01;
            state_d      = S_FETCH;
         end
         S_MEMWR: begin
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
            if (bus.mem_ready) state_d = S_FETCH;
            else if (timeout_hit) begin
               state_d = S_ERR; trap_d = 1'b1; cause_d = CAUSE_TIMEOUT;
            end
         end
         S_RTYPEEX: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = r_alu;
            state_d        = S_RTYPEWB;
`ifdef ILLEGAL_TRAP_EN
            if (!funct_ok) begin
               state_d = S_ERR; trap_d = 1'b1; cause_d = CAUSE_ILLEGAL;
            end
`endif
         end
         S_RTYPEWB: begin
            bus.regwrite = 1'b1;
            bus.regdst   = 2'b01;
            state_d      = S_FETCH;
         end
         S_BEQEX, S_BNEEX: begin
            bus.alusrca    = 1'b1;
            bus.alucontrol = ALU_SUB;
            bus.pcsrc      = 2'b01;
            state_d        = S_FETCH;
         end
         S_IMMEX: begin
            bus.alusrca    = 1'b1;
            bus.alusrcb    = 2'b10;
            bus.alucontrol = i_alu;
            bus.zext       = imm_zext;
            state_d        = S_IMMWB;
         end
         S_IMMWB: begin
            bus.regwrite   = 1'b1;
            bus.alucontrol = i_alu;
            bus.zext       = imm_zext;
            state_d        = S_FETCH;
         end
         S_JEX: begin
            bus.pcsrc = 2'b10;
            pcwrite   = 1'b1;
            state_d   = S_FETCH;
         end
         S_JALEX: begin
            bus.regwrite = 1'b1;
            bus.regdst   = 2'b10;
            bus.memtoreg = 2'b10;
            bus.pcsrc    = 2'b10;
            pcwrite      = 1'b1;
            state_d      = S_FETCH;
         end
         default: state_d = S_ERR;
      endcase

      bus.pcen = pcwrite | ((state_q == S_BEQEX) & bus.zero) | ((state_q == S_BNEEX) & ~bus.zero);
   end

   assign bus.state      = state_q;
   assign bus.trap       = trap_q;
   assign bus.trap_cause = cause_q;
endmodule
